// File: rtl/axis_frame_tx.sv
// axis_frame_tx
// Store-and-forward AXI-Stream frame transmitter. Bytes from the write port
// are buffered in block RAM as {last, data} words. A frame only becomes
// eligible for transmission once its last beat is committed. Frames that
// overflow the buffer are discarded whole.
//
// Ports
//   m_aclk         clock
//   m_sresetn      synchronous active-low reset
//   wr_en          write strobe, one beat per cycle
//   wr_data        write beat
//   wr_last        final beat of the frame (qualifies wr_en), commits it
//   wr_full        buffer holds 2^ADDR_WIDTH beats
//   wr_drop        one-cycle pulse: the frame just ended was discarded
//   frame_cnt      committed frames not yet fully transmitted
//   m_axis_tdata   output beat
//   m_axis_tvalid  output beat valid
//   m_axis_tlast   output beat ends its frame
//   m_axis_trdy    downstream ready
//
// Reader FSM
//   state   | meaning
//   S_IDLE  | nothing in flight, output empty
//   S_FETCH | RAM read in flight, output register empty
//   S_SEND  | output register holds a beat (tvalid=1)
module axis_frame_tx #(
   parameter int AXI_DATA_WIDTH = 8,
   parameter int ADDR_WIDTH     = 11
) (
   input  logic                      m_aclk,
   input  logic                      m_sresetn,
   input  logic                      wr_en,
   input  logic [AXI_DATA_WIDTH-1:0] wr_data,
   input  logic                      wr_last,
   output logic                      wr_full,
   output logic                      wr_drop,
   output logic [ADDR_WIDTH:0]       frame_cnt,
   output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
   output logic                      m_axis_tvalid,
   output logic                      m_axis_tlast,
   input  logic                      m_axis_trdy
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int PW    = ADDR_WIDTH + 1;
   localparam int WW    = AXI_DATA_WIDTH + 1;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND} state_t;

   state_t          state, state_next;
   logic [PW-1:0]   wr_ptr, rd_ptr, fetch_ptr, frame_start, used;
   logic            drop;
   logic [WW-1:0]   mem [DEPTH];
   logic [WW-1:0]   ram_q, skid_word, out_word;
   logic            ram_q_vld, skid_vld, out_vld;
   logic            wr_accept, commit, drop_end;
   logic            hs, avail, rd_issue;
   logic [1:0]      occ;

   // used never exceeds DEPTH, so its MSB alone marks full
   assign used    = wr_ptr - rd_ptr;
   assign wr_full = used[ADDR_WIDTH];

   assign wr_accept = wr_en && !wr_full && !drop;
   assign commit    = wr_accept && wr_last;
   assign drop_end  = wr_en && wr_last && (wr_full || drop);

   // frame_start doubles as the end of committed data: the reader may
   // fetch only up to it
   assign avail = (fetch_ptr != frame_start);

   assign out_vld       = (state == S_SEND);
   assign hs            = out_vld && m_axis_trdy;
   assign m_axis_tvalid = out_vld;
   assign m_axis_tdata  = out_word[AXI_DATA_WIDTH-1:0];
   assign m_axis_tlast  = out_word[AXI_DATA_WIDTH];

   always_ff @(posedge m_aclk) begin
      if (!m_sresetn) begin
         wr_ptr      <= '0;
         frame_start <= '0;
         drop        <= 1'b0;
         wr_drop     <= 1'b0;
      end else begin
         wr_drop <= drop_end;
         if (drop_end) begin
            wr_ptr <= frame_start;
            drop   <= 1'b0;
         end else if (wr_accept) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (wr_last) frame_start <= wr_ptr + PW'(1);
         end else if (wr_en) begin
            drop <= 1'b1;
         end
      end
   end

   always_ff @(posedge m_aclk) begin
      if (wr_accept) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {wr_last, wr_data};
   end

   always_ff @(posedge m_aclk) begin
      if (rd_issue) ram_q <= mem[fetch_ptr[ADDR_WIDTH-1:0]];
   end

   // A read may be issued only if, after this edge, output+skid hold at
   // most one beat; the returning word then always has a slot even if
   // trdy stays low.
   always_comb begin
      state_next = state;
      rd_issue   = 1'b0;
      occ        = 2'(out_vld) + 2'(skid_vld) + 2'(ram_q_vld) - 2'(hs);
      if (avail && occ < 2'd2) rd_issue = 1'b1;
      case (state)
         S_IDLE:  if (rd_issue) state_next = S_FETCH;
         S_FETCH: state_next = S_SEND;
         S_SEND: begin
            if ((out_vld && !hs) || skid_vld || ram_q_vld) state_next = S_SEND;
            else if (rd_issue)                             state_next = S_FETCH;
            else                                           state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge m_aclk) begin
      if (!m_sresetn) state <= S_IDLE;
      else            state <= state_next;
   end

   always_ff @(posedge m_aclk) begin
      if (!m_sresetn) begin
         rd_ptr    <= '0;
         fetch_ptr <= '0;
         ram_q_vld <= 1'b0;
         skid_vld  <= 1'b0;
         skid_word <= '0;
         out_word  <= '0;
         frame_cnt <= '0;
      end else begin
         ram_q_vld <= rd_issue;
         if (rd_issue) fetch_ptr <= fetch_ptr + PW'(1);
         if (hs)       rd_ptr    <= rd_ptr + PW'(1);

         // skid holds the older beat, so it drains into the output first
         if (!out_vld || hs) begin
            if (skid_vld) begin
               out_word <= skid_word;
               skid_vld <= ram_q_vld;
               if (ram_q_vld) skid_word <= ram_q;
            end else if (ram_q_vld) begin
               out_word <= ram_q;
            end
         end else if (ram_q_vld) begin
            skid_word <= ram_q;
            skid_vld  <= 1'b1;
         end

         if (commit && !(hs && m_axis_tlast))      frame_cnt <= frame_cnt + 1'b1;
         else if (!commit && hs && m_axis_tlast)   frame_cnt <= frame_cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_axis_frame_tx.sv
// Bench for axis_frame_tx: one instance at the default depth (2048) and
// one at ADDR_WIDTH=4 (depth 16) for overflow and wrap. The reference
// model is a queue of expected {last,data} beats per instance; a frame is
// queued when written, unless it is expected to be dropped.
module tb_axis_frame_tx;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [1:0]  wr_en, wr_last, trdy;
   logic [7:0]  wdata [2];

   logic        tvalid_a, tlast_a, full_a, drop_a;
   logic [7:0]  tdata_a;
   logic [11:0] fc_a;
   logic        tvalid_b, tlast_b, full_b, drop_b;
   logic [7:0]  tdata_b;
   logic [4:0]  fc_b;

   axis_frame_tx #(.AXI_DATA_WIDTH(8), .ADDR_WIDTH(11)) dut_a (
      .m_aclk(clk), .m_sresetn(rst_n),
      .wr_en(wr_en[0]), .wr_data(wdata[0]), .wr_last(wr_last[0]),
      .wr_full(full_a), .wr_drop(drop_a), .frame_cnt(fc_a),
      .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a),
      .m_axis_tlast(tlast_a), .m_axis_trdy(trdy[0]));

   axis_frame_tx #(.AXI_DATA_WIDTH(8), .ADDR_WIDTH(4)) dut_b (
      .m_aclk(clk), .m_sresetn(rst_n),
      .wr_en(wr_en[1]), .wr_data(wdata[1]), .wr_last(wr_last[1]),
      .wr_full(full_b), .wr_drop(drop_b), .frame_cnt(fc_b),
      .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b),
      .m_axis_tlast(tlast_b), .m_axis_trdy(trdy[1]));

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [8:0]  qa[$];
   logic [8:0]  qb[$];
   logic [7:0]  pay[$];
   int          rx_cnt [2];
   logic        stall_p [2];
   logic [8:0]  stall_w [2];

   function automatic logic get_tv(int i);    return (i == 0) ? tvalid_a : tvalid_b;     endfunction
   function automatic logic get_tl(int i);    return (i == 0) ? tlast_a  : tlast_b;      endfunction
   function automatic logic [7:0] get_td(int i); return (i == 0) ? tdata_a : tdata_b;    endfunction
   function automatic logic get_full(int i);  return (i == 0) ? full_a   : full_b;       endfunction
   function automatic logic get_drop(int i);  return (i == 0) ? drop_a   : drop_b;       endfunction
   function automatic logic [11:0] get_fc(int i); return (i == 0) ? fc_a : 12'(fc_b);    endfunction

   function automatic int qsize(int i); return (i == 0) ? qa.size() : qb.size(); endfunction
   function automatic void qpush(int i, logic [8:0] v);
      if (i == 0) qa.push_back(v); else qb.push_back(v);
   endfunction
   function automatic logic [8:0] qpop(int i);
      return (i == 0) ? qa.pop_front() : qb.pop_front();
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Output monitor: every handshake must match the head of the model
   // queue, and a stalled beat must hold until accepted.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            stall_p[i] = 1'b0;
         end else begin
            if (stall_p[i])
               chk($sformatf("hold%0d", i), {get_tv(i), get_tl(i), get_td(i)}, {1'b1, stall_w[i]});
            if (get_tv(i) && trdy[i]) begin
               chk($sformatf("beat_expected%0d", i), 32'(qsize(i) != 0), 1);
               if (qsize(i) != 0)
                  chk($sformatf("beat%0d_n%0d", i, rx_cnt[i]), {get_tl(i), get_td(i)}, qpop(i));
               rx_cnt[i]++;
            end
            stall_p[i] = get_tv(i) && !trdy[i];
            stall_w[i] = {get_tl(i), get_td(i)};
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_rand(input int len);
      pay.delete();
      for (int k = 0; k < len; k++) pay.push_back(8'($urandom));
   endtask

   task automatic write_frame(input int i, input bit keep, input bit rnd_trdy, input bit gaps);
      int len;
      len = pay.size();
      for (int k = 0; k < len; k++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            wr_en[i] = 1'b0; wr_last[i] = 1'b0;
            if (rnd_trdy) trdy[i] = 1'($urandom_range(0, 1));
            step();
         end
         wr_en[i] = 1'b1; wdata[i] = pay[k]; wr_last[i] = (k == len - 1);
         if (rnd_trdy) trdy[i] = 1'($urandom_range(0, 1));
         step();
      end
      wr_en[i] = 1'b0; wr_last[i] = 1'b0;
      if (keep)
         for (int k = 0; k < len; k++) qpush(i, {k == len - 1, pay[k]});
   endtask

   // keep the writer far enough ahead of the reader that nothing overflows
   task automatic throttle(input int i, input int len, input int depth, input bit rnd);
      int budget;
      budget = 50000;
      while (qsize(i) + len > depth && budget > 0) begin
         if (rnd) trdy[i] = 1'($urandom_range(0, 1));
         step();
         budget--;
      end
      chk($sformatf("throttle%0d", i), 32'(qsize(i) + len <= depth), 1);
   endtask

   task automatic drain(input int i, input bit rnd);
      int budget;
      budget = 30000;
      while (qsize(i) != 0 && budget > 0) begin
         trdy[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         step();
         budget--;
      end
      chk($sformatf("drain_left%0d", i), qsize(i), 0);
      chk($sformatf("drain_tvalid%0d", i), get_tv(i), 0);
      chk($sformatf("drain_fcnt%0d", i), get_fc(i), 0);
   endtask

   initial begin
      int stalls, rx0, waitc;
      rst_n = 1'b0; wr_en = '0; wr_last = '0; trdy = '0;
      wdata[0] = '0; wdata[1] = '0;
      rx_cnt[0] = 0; rx_cnt[1] = 0;
      stall_p[0] = 1'b0; stall_p[1] = 1'b0;
      stall_w[0] = '0; stall_w[1] = '0;
      step(); step(); step();

      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_tvalid%0d", i), get_tv(i), 0);
         chk($sformatf("rst_tlast%0d", i), get_tl(i), 0);
         chk($sformatf("rst_tdata%0d", i), get_td(i), 0);
         chk($sformatf("rst_full%0d", i), get_full(i), 0);
         chk($sformatf("rst_drop%0d", i), get_drop(i), 0);
         chk($sformatf("rst_fcnt%0d", i), get_fc(i), 0);
      end
      rst_n = 1'b1;
      step();

      // single 4-byte frame, trdy high: tvalid 2 cycles after wr_last
      trdy[0] = 1'b1;
      pay.delete();
      pay.push_back(8'h11); pay.push_back(8'h22); pay.push_back(8'h33); pay.push_back(8'h44);
      write_frame(0, 1'b1, 1'b0, 1'b0);
      chk("single_fcnt1", fc_a, 1);
      step();
      chk("single_lat1", tvalid_a, 0);
      step();
      chk("single_lat2", tvalid_a, 1);
      chk("single_first", tdata_a, 8'h11);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("single_vld%0d", k), tvalid_a, 1);
         chk($sformatf("single_last%0d", k), tlast_a, (k == 3) ? 1 : 0);
         step();
      end
      chk("single_end_vld", tvalid_a, 0);
      chk("single_fcnt0", fc_a, 0);

      // back-to-back frames of 1, 5, 64 beats, then released: no bubbles
      trdy[0] = 1'b0;
      fill_rand(1);  write_frame(0, 1'b1, 1'b0, 1'b0);
      fill_rand(5);  write_frame(0, 1'b1, 1'b0, 1'b0);
      fill_rand(64); write_frame(0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) step();
      chk("b2b_fcnt3", fc_a, 3);
      trdy[0] = 1'b1;
      stalls = 0;
      rx0 = rx_cnt[0];
      for (int k = 0; k < 70; k++) begin
         if (!tvalid_a) stalls++;
         step();
      end
      chk("b2b_stalls", stalls, 0);
      chk("b2b_beats", rx_cnt[0] - rx0, 70);
      chk("b2b_end_vld", tvalid_a, 0);
      chk("b2b_fcnt0", fc_a, 0);

      // 20 random frames under random backpressure and write gaps
      for (int f = 0; f < 20; f++) begin
         int len;
         len = $urandom_range(1, 300);
         throttle(0, len, 2048, 1'b1);
         fill_rand(len);
         write_frame(0, 1'b1, 1'b1, 1'b1);
      end
      drain(0, 1'b1);

      // overflow on the 16-deep instance
      trdy[1] = 1'b0;
      fill_rand(10);
      write_frame(1, 1'b1, 1'b0, 1'b0);
      chk("ovf_fcnt_a", fc_b, 1);
      chk("ovf_full_a", full_b, 0);
      fill_rand(10);
      for (int k = 0; k < 10; k++) begin
         wr_en[1] = 1'b1; wdata[1] = pay[k]; wr_last[1] = (k == 9);
         step();
         if (k == 4) chk("ovf_full15", full_b, 0);
         if (k == 5) chk("ovf_full16", full_b, 1);
         if (k < 9)  chk($sformatf("ovf_nodrop%0d", k), drop_b, 0);
      end
      wr_en[1] = 1'b0; wr_last[1] = 1'b0;
      chk("ovf_drop", drop_b, 1);
      chk("ovf_fcnt_b", fc_b, 1);
      step();
      chk("ovf_drop_pulse", drop_b, 0);
      chk("ovf_full_rewind", full_b, 0);
      rx0 = rx_cnt[1];
      drain(1, 1'b0);
      for (int k = 0; k < 5; k++) step();
      chk("ovf_beats", rx_cnt[1] - rx0, 10);
      chk("ovf_idle", tvalid_b, 0);

      // 100 frames of 7 beats through the 16-deep buffer
      trdy[1] = 1'b1;
      rx0 = rx_cnt[1];
      for (int f = 0; f < 100; f++) begin
         throttle(1, 7, 16, 1'b0);
         fill_rand(7);
         write_frame(1, 1'b1, 1'b0, 1'b0);
      end
      drain(1, 1'b0);
      chk("wrap_beats", rx_cnt[1] - rx0, 700);

      // reset while beat 3 of 8 is on the output
      trdy[0] = 1'b0;
      fill_rand(8);
      write_frame(0, 1'b1, 1'b0, 1'b0);
      waitc = 0;
      while (!tvalid_a && waitc < 20) begin step(); waitc++; end
      chk("rstmid_vld", tvalid_a, 1);
      trdy[0] = 1'b1;
      step(); step();
      chk("rstmid_beat3", tdata_a, pay[2]);
      rst_n = 1'b0;
      step();
      chk("rstmid_tvalid", tvalid_a, 0);
      chk("rstmid_fcnt", fc_a, 0);
      qa.delete(); qb.delete();
      rst_n = 1'b1;
      step();
      fill_rand(2);
      write_frame(0, 1'b1, 1'b0, 1'b0);
      drain(0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axis_frame_tx.md
# axis_frame_tx

Store-and-forward AXI-Stream frame transmitter. It accepts bytes from an upstream MAC/IP-layer producer on a simple write port, buffers each frame in block RAM, and drives the frame out on an AXI-Stream master port with `tlast` framing and `trdy` backpressure. A frame becomes visible downstream only after its last byte is committed. Frames that overflow the buffer are discarded whole. The block is the transmit-side counterpart of the stream receivers used throughout the datapath.

## Interface
- `AXI_DATA_WIDTH`, 8: width of `wr_data` and `m_axis_tdata`.
- `ADDR_WIDTH`, 11: buffer depth is 2^ADDR_WIDTH beats (2048).

Ports:
- `m_aclk`, in, 1: single clock for the whole block.
- `m_sresetn`, in, 1: reset, synchronous, active-low.
- `wr_en`, in, 1: write strobe; one beat per cycle when high.
- `wr_data`, in, AXI_DATA_WIDTH: write beat.
- `wr_last`, in, 1: qualifies `wr_en`; marks the final beat of a frame and commits it.
- `wr_full`, out, 1: buffer holds 2^ADDR_WIDTH beats.
- `wr_drop`, out, 1: one-cycle pulse; the frame whose `wr_last` was just written has been discarded.
- `frame_cnt`, out, ADDR_WIDTH+1: number of committed frames not yet fully transmitted.
- `m_axis_tdata`, out, AXI_DATA_WIDTH: output beat.
- `m_axis_tvalid`, out, 1: output beat valid.
- `m_axis_tlast`, out, 1: output beat is the final beat of its frame.
- `m_axis_trdy`, in, 1: downstream ready.

## Operation
- **Reset** (`m_sresetn`=0 at a rising edge):
  - All pointers and `frame_cnt` return to 0.
  - `wr_full`, `wr_drop`, `m_axis_tvalid`, `m_axis_tlast` and `m_axis_tdata` are 0 from the following cycle.
  - A partially written or partially sent frame is lost. RAM contents are don't-care.
- **Writer:**
  - Each accepted beat is stored at `wr_ptr`, and `wr_ptr` increments, wrapping modulo 2^ADDR_WIDTH. The stored word is {`wr_last`, `wr_data`}.
  - `frame_start` holds the `wr_ptr` value at the first beat of the current frame.
  - Used count is `wr_ptr - rd_ptr`, computed with ADDR_WIDTH+1-bit pointers; the extra MSB distinguishes full from empty.
- **Overflow:**
  - A `wr_en` while `wr_full`=1 sets an internal `drop` flag. That beat and all later beats of the frame are discarded.
  - At that frame's `wr_last`, `wr_ptr` rewinds to `frame_start`, `wr_drop` pulses, `frame_cnt` is not incremented, and `drop` clears.
  - Any frame longer than 2^ADDR_WIDTH beats is therefore always dropped.
- **Commit:** a non-dropped `wr_en`&`wr_last` increments `frame_cnt`.
- **Reader FSM:**
  - IDLE: stay while `frame_cnt`=0. Otherwise issue a RAM read at `rd_ptr` and go to FETCH.
  - FETCH: the registered RAM output loads the output register and `m_axis_tvalid` rises; go to SEND. Prefetch of the next beat begins in the same cycle.
  - SEND: on each `m_axis_tvalid`&`m_axis_trdy` handshake, `rd_ptr` advances and the next beat is presented the following cycle, with no bubble while `trdy` stays high. The prefetch/skid register must preserve the beat sequence under arbitrary `trdy` toggling.
  - On a handshake with `tlast`=1: decrement `frame_cnt`. If the result is nonzero, continue directly with the next frame's first beat, still without a bubble. Otherwise deassert `tvalid` and return to IDLE.
  - The reader never reads past the last committed beat.
- **AXI rules:**
  - Once `tvalid`=1, `tdata`, `tlast` and `tvalid` hold stable until the handshake.
  - `tvalid` never depends combinationally on `trdy`.
- **Simultaneous commit and final handshake:** `frame_cnt` is unchanged net (+1 and −1).

## Timing
- **Latency:** `wr_last` accepted at edge N makes `frame_cnt` nonzero from N. With the reader IDLE and the buffer otherwise empty, `m_axis_tvalid` is high after edge N+2.
- **Throughput:** one beat per cycle on both ports.
- **`wr_full`:** registered, reflecting pointers after edge N. Freed space is visible one cycle after the handshake that frees it.
- **`wr_drop`:** high for exactly the cycle after the dropped frame's `wr_last` edge.

## Test plan
- **Single frame:** 4-byte frame 0x11,0x22,0x33,0x44 with `trdy`=1 → `tvalid` rises 2 cycles after `wr_last`; beats arrive on 4 consecutive cycles; `tlast` only on 0x44; `frame_cnt` goes 1→0.
- **Back-to-back:** three frames of lengths 1, 5, 64 written back-to-back, `trdy`=1 → 70 beats with no idle cycles after the first beat; `tlast` on beats 1, 6, 70.
- **Backpressure:** random `trdy` (50%) over 20 frames of random length 1–300 → output byte stream and `tlast` positions match the input exactly; `tdata` stable while `tvalid`&!`trdy`.
- **Overflow:** `ADDR_WIDTH`=4, `trdy`=0, write a 10-beat frame then a 10-beat frame → `wr_full` at beat 16; second frame gives `wr_drop`=1 for one cycle and `frame_cnt`=1. Release `trdy` → only the first 10 beats appear.
- **Wrap:** `ADDR_WIDTH`=4, stream 100 frames of 7 beats with `trdy`=1 → all 700 beats in order across pointer wrap.
- **Reset mid-frame:** assert `m_sresetn`=0 during beat 3 of 8 being sent → `tvalid`=0 the next cycle and `frame_cnt`=0. A new 2-byte frame after reset transmits correctly.
